accum_alu: RTL and testbench

Parametrised accumulator ALU with a handshaked operation port, an iterative multiplier and an overflow/error state machine. Operand B arrives with an opcode. The result is written back into an internal WIDTH-bit accumulator, and completion is signalled with a one-cycle `result_valid` pulse. It is the WIDTH-generic successor of the 8-bit accumulator ALU and sits between the datapath register file and the output bus.

---
 rtl/accum_alu_pkg.sv | 24 ++
 rtl/accum_alu_if.sv | 30 +++
 rtl/accum_alu_seq_multiplier.sv | 57 +++++
 rtl/accum_alu.sv | 113 +++++++++++
 tb/tb_accum_alu.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/accum_alu_pkg.sv
// Shared opcode and state encodings for the accumulator ALU.
package accum_alu_pkg;

  localparam int unsigned OPCODE_W = 3;

  typedef enum logic [OPCODE_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NOT  = 3'd3,
    OP_ADD  = 3'd4,
    OP_SUB  = 3'd5,
    OP_MUL  = 3'd6,
    OP_LOAD = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    ST_OFF   = 2'b00,
    ST_READY = 2'b01,
    ST_RUN   = 2'b10,
    ST_ERROR = 2'b11
  } state_e;

endpackage

// File: rtl/accum_alu_if.sv
// Operation/result bundle between the register file side and the accumulator ALU.
interface accum_alu_if #(
  parameter int unsigned WIDTH = 8
);
  import accum_alu_pkg::*;

  logic                on;
  logic                clr;
  logic                ack;
  logic                op_valid;
  logic                op_ready;
  logic [OPCODE_W-1:0] op_code;
  logic [WIDTH-1:0]    op_b;
  logic [WIDTH-1:0]    result;
  logic                result_valid;
  logic                overflow;
  logic                error;
  logic [1:0]          state;

  modport master (
    output on, clr, ack, op_valid, op_code, op_b,
    input  op_ready, result, result_valid, overflow, error, state
  );

  modport slave (
    input  on, clr, ack, op_valid, op_code, op_b,
    output op_ready, result, result_valid, overflow, error, state
  );

endinterface

// File: rtl/accum_alu_seq_multiplier.sv
// Shift-add multiplier: one partial product per cycle over WIDTH cycles.
module seq_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_prod;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic [2*WIDTH-1:0] w_step;

  assign w_step = r_mplier[0] ? (r_prod + r_mcand) : r_prod;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (abort) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (start) begin
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_prod   <= '0;
      r_cnt    <= CW'(WIDTH);
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_prod   <= w_step;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - 1'b1;
      if (r_cnt == CW'(1)) r_busy <= 1'b0;
    end
  end

  // The final step is exposed combinationally so the caller can write it on the last RUN edge.
  assign busy    = r_busy;
  assign done    = r_busy && (r_cnt == CW'(1));
  assign product = w_step;

endmodule

// File: rtl/accum_alu.sv
// WIDTH-generic accumulator ALU: FSM, accumulator, logic/add/sub datapath and iterative MUL.
module accum_alu
  import accum_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  accum_alu_if.slave  bus
);

  state_e             r_state, w_next_state;
  logic [WIDTH-1:0]   r_acc, w_next_acc;
  logic               r_valid, w_valid;
  logic               r_ovf, w_ovf;
  logic               w_start, w_abort;
  logic               w_mul_busy, w_mul_done;
  logic [2*WIDTH-1:0] w_product;
  logic [WIDTH:0]     w_sum, w_diff;

  assign w_sum  = {1'b0, r_acc} + {1'b0, bus.op_b};
  assign w_diff = {1'b0, r_acc} - {1'b0, bus.op_b};

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (w_start),
    .abort   (w_abort),
    .a       (r_acc),
    .b       (bus.op_b),
    .busy    (w_mul_busy),
    .done    (w_mul_done),
    .product (w_product)
  );

  always_comb begin
    w_next_state = r_state;
    w_next_acc   = r_acc;
    w_valid      = 1'b0;
    w_ovf        = 1'b0;
    w_start      = 1'b0;
    w_abort      = w_mul_busy && (!bus.on || bus.clr);
    if (!bus.on) begin
      w_next_state = ST_OFF;
    end else if (bus.clr) begin
      w_next_state = ST_READY;
      w_next_acc   = '0;
    end else begin
      case (r_state)
        ST_OFF: w_next_state = ST_READY;
        ST_READY: begin
          if (bus.op_valid) begin
            w_valid = 1'b1;
            case (opcode_e'(bus.op_code))
              OP_AND:  w_next_acc = r_acc & bus.op_b;
              OP_OR:   w_next_acc = r_acc | bus.op_b;
              OP_XOR:  w_next_acc = r_acc ^ bus.op_b;
              OP_NOT:  w_next_acc = ~r_acc;
              OP_ADD: begin
                w_next_acc = w_sum[WIDTH-1:0];
                w_ovf      = w_sum[WIDTH];
              end
              OP_SUB: begin
                w_next_acc = w_diff[WIDTH-1:0];
                w_ovf      = w_diff[WIDTH];
              end
              OP_MUL: begin
                w_valid      = 1'b0;
                w_start      = 1'b1;
                w_next_state = ST_RUN;
              end
              default: w_next_acc = bus.op_b;
            endcase
            if (w_ovf) w_next_state = ST_ERROR;
          end
        end
        ST_RUN: begin
          if (w_mul_done) begin
            w_next_acc   = w_product[WIDTH-1:0];
            w_valid      = 1'b1;
            w_ovf        = |w_product[2*WIDTH-1:WIDTH];
            w_next_state = w_ovf ? ST_ERROR : ST_READY;
          end
        end
        default: begin
          if (bus.ack) w_next_state = ST_READY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_OFF;
      r_acc   <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_acc   <= w_next_acc;
      r_valid <= w_valid;
      r_ovf   <= w_ovf;
    end
  end

  assign bus.op_ready     = (r_state == ST_READY);
  assign bus.error        = (r_state == ST_ERROR);
  assign bus.state        = r_state;
  assign bus.result       = r_acc;
  assign bus.result_valid = r_valid;
  assign bus.overflow     = r_ovf;

endmodule

// File: tb/tb_accum_alu.sv
// Scoreboard bench for accum_alu: directed scenarios plus random ops against an arithmetic model.
module tb_accum_alu;
  import accum_alu_pkg::*;

  localparam int unsigned W    = 8;
  localparam int unsigned MASK = (1 << W) - 1;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  accum_alu_if #(.WIDTH(W)) bus();

  accum_alu #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned m_acc = 0;
  bit          m_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst && bus.result_valid === 1'b1) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_valid: result 0x%0h with no pending op at %0t", bus.result, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (bus.result !== e.res || bus.overflow !== e.ovf) begin
          n_err++;
          $display("FAIL result: got 0x%0h ovf %0b expected 0x%0h ovf %0b at %0t",
                   bus.result, bus.overflow, e.res, e.ovf, $time);
        end
      end
    end
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour in plain unsigned arithmetic.
  task automatic model(input logic [2:0] code, input logic [W-1:0] b);
    int unsigned r;
    bit          o;
    o = 0;
    case (code)
      3'd0: r = m_acc & b;
      3'd1: r = m_acc | b;
      3'd2: r = m_acc ^ b;
      3'd3: r = ~m_acc & MASK;
      3'd4: begin r = m_acc + b; o = (r > MASK); end
      3'd5: begin o = (m_acc < b); r = m_acc - b; end
      3'd6: begin r = m_acc * b; o = (r > MASK); end
      default: r = b;
    endcase
    m_acc = r & MASK;
    m_err = o;
    q.push_back('{res: W'(m_acc), ovf: o});
  endtask

  task automatic do_op(input logic [2:0] code, input logic [W-1:0] b, input bit expect_result);
    int unsigned guard = 0;
    while (bus.op_ready !== 1'b1 && guard < 50) begin
      bus.op_valid = 1'b0;
      edge1();
      guard++;
    end
    if (bus.op_ready !== 1'b1) begin
      chk("op_ready_timeout", 0, 1);
    end else begin
      bus.op_valid = 1'b1;
      bus.op_code  = code;
      bus.op_b     = b;
      edge1();
      if (expect_result) model(code, b);
    end
  endtask

  task automatic idle();
    bus.op_valid = 1'b0;
    edge1();
  endtask

  task automatic wait_not_run();
    int unsigned guard = 0;
    bus.op_valid = 1'b0;
    while (bus.state === 2'b10 && guard < 50) begin
      edge1();
      guard++;
    end
    if (bus.state === 2'b10) chk("run_timeout", 1, 0);
  endtask

  task automatic do_ack();
    wait_not_run();
    bus.ack = 1'b1;
    edge1();
    bus.ack = 1'b0;
    m_err = 0;
    chk("ack_state", bus.state, 1);
    chk("ack_result", bus.result, m_acc);
  endtask

  task automatic do_clr();
    wait_not_run();
    bus.clr = 1'b1;
    edge1();
    bus.clr = 1'b0;
    m_acc = 0;
    m_err = 0;
    chk("clr_state", bus.state, 1);
    chk("clr_result", bus.result, 0);
  endtask

  initial begin
    logic [2:0]   code;
    logic [W-1:0] b;
    int           cnt;

    bus.on = 1'b0; bus.clr = 1'b0; bus.ack = 1'b0;
    bus.op_valid = 1'b0; bus.op_code = '0; bus.op_b = '0;
    repeat (2) edge1();
    chk("rst_state", bus.state, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_ready", bus.op_ready, 0);
    chk("rst_valid", bus.result_valid, 0);
    chk("rst_error", bus.error, 0);
    rst = 1'b1;
    bus.on = 1'b1;
    edge1();
    chk("on_ready", bus.state, 1);

    // 1: load/add, carry-out overflow
    do_op(3'd7, 8'h0F, 1);
    do_op(3'd4, 8'hF0, 1);
    chk("add_ff", bus.result, 8'hFF);
    do_op(3'd4, 8'h01, 1);
    bus.op_valid = 1'b0;
    chk("add_wrap", bus.result, 8'h00);
    chk("add_ovf", bus.overflow, 1);
    chk("add_err_state", bus.state, 3);
    chk("add_err_ready", bus.op_ready, 0);
    chk("add_err_flag", bus.error, 1);

    // 2: ack, borrow overflow, clr
    do_ack();
    do_op(3'd5, 8'h01, 1);
    bus.op_valid = 1'b0;
    chk("sub_wrap", bus.result, 8'hFF);
    chk("sub_err_state", bus.state, 3);
    do_clr();

    // 3: multiply timing and overflow
    do_op(3'd7, 8'h0C, 1);
    do_op(3'd6, 8'h0A, 1);
    bus.op_valid = 1'b0;
    cnt = 0;
    while (bus.op_ready !== 1'b1 && cnt < 40) begin cnt++; edge1(); end
    chk("mul_busy_cycles", cnt, W);
    chk("mul_result", bus.result, 8'h78);
    chk("mul_valid", bus.result_valid, 1);
    do_op(3'd6, 8'h03, 1);
    wait_not_run();
    chk("mul_ovf_result", bus.result, 8'h68);
    chk("mul_ovf_state", bus.state, 3);
    do_ack();

    // 4: back-to-back logic ops
    do_op(3'd7, 8'hA5, 1);
    do_op(3'd2, 8'hFF, 1);
    chk("xor_valid", bus.result_valid, 1);
    chk("xor_res", bus.result, 8'h5A);
    do_op(3'd3, 8'h00, 1);
    chk("not_valid", bus.result_valid, 1);
    chk("not_res", bus.result, 8'hA5);
    do_op(3'd0, 8'h3C, 1);
    chk("and_valid", bus.result_valid, 1);
    chk("and_res", bus.result, 8'h24);
    do_op(3'd1, 8'h81, 1);
    chk("or_valid", bus.result_valid, 1);
    chk("or_res", bus.result, 8'hA5);
    idle();

    // 5a: clr aborts a multiply
    do_op(3'd7, 8'h0C, 1);
    do_op(3'd6, 8'h0A, 0);
    bus.op_valid = 1'b0;
    repeat (2) edge1();
    bus.clr = 1'b1;
    edge1();
    bus.clr = 1'b0;
    m_acc = 0;
    chk("abort_clr_state", bus.state, 1);
    chk("abort_clr_result", bus.result, 0);
    cnt = 0;
    repeat (12) begin edge1(); if (bus.result_valid === 1'b1) cnt++; end
    chk("abort_clr_no_valid", cnt, 0);

    // 5b: on=0 aborts a multiply and holds acc
    do_op(3'd7, 8'h0C, 1);
    do_op(3'd6, 8'h0A, 0);
    bus.op_valid = 1'b0;
    repeat (2) edge1();
    bus.on = 1'b0;
    edge1();
    chk("abort_off_state", bus.state, 0);
    chk("abort_off_result", bus.result, 8'h0C);
    repeat (10) edge1();
    chk("abort_off_held", bus.result, 8'h0C);
    bus.on = 1'b1;
    edge1();
    chk("abort_off_back", bus.state, 1);

    // 5c: asynchronous reset mid-multiply
    do_op(3'd6, 8'h0A, 0);
    bus.op_valid = 1'b0;
    repeat (2) edge1();
    #2 rst = 1'b0;
    #1;
    chk("abort_rst_state", bus.state, 0);
    chk("abort_rst_result", bus.result, 0);
    chk("abort_rst_ready", bus.op_ready, 0);
    chk("abort_rst_error", bus.error, 0);
    chk("abort_rst_valid", bus.result_valid, 0);
    m_acc = 0;
    m_err = 0;
    repeat (2) edge1();
    rst = 1'b1;
    edge1();
    chk("rst_release_state", bus.state, 1);

    // 6: clr wins over a same-cycle operation
    do_op(3'd7, 8'h33, 1);
    bus.clr      = 1'b1;
    bus.op_valid = 1'b1;
    bus.op_code  = 3'd7;
    bus.op_b     = 8'h55;
    edge1();
    bus.clr      = 1'b0;
    bus.op_valid = 1'b0;
    m_acc = 0;
    chk("clr_vs_op_result", bus.result, 0);
    chk("clr_vs_op_valid", bus.result_valid, 0);

    // Random operations
    for (int i = 0; i < 200; i++) begin
      if (m_err) begin
        if ($urandom_range(1) == 0) do_ack(); else do_clr();
      end
      code = 3'($urandom_range(7));
      b    = W'($urandom);
      if ($urandom_range(7) == 0) b = (code == 3'd5) ? W'(m_acc + 1) : 8'hFF;
      do_op(code, b, 1);
      if ($urandom_range(3) == 0) idle();
    end
    wait_not_run();
    repeat (5) idle();
    chk("scoreboard_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
